updown_mod_counter: RTL and testbench

- Parametrised up/down modulo counter; next generation of the 4-bit free-running counter.
- Adds configurable width and terminal value, direction control, enable, prescaler, synchronous clear/load, wrap or saturate mode, terminal-count pulse and sticky wrap flag.
- Used as a timebase / event counter.
- Multiple instances cascade through tc into en.

---
 rtl/updown_mod_counter_if.sv | 24 ++
 rtl/updown_mod_counter.sv | 85 ++++++++
 tb/tb_updown_mod_counter.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/updown_mod_counter_if.sv
// rtl/updown_mod_counter_if.sv - control and status bundle of the up/down modulo counter
interface updown_mod_counter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             en;
    logic             up_dn;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             flag_clr;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap_flag;

    modport master (
        output en, up_dn, clr, load, load_val, flag_clr,
        input  q, tc, wrap_flag
    );

    modport slave (
        input  en, up_dn, clr, load, load_val, flag_clr,
        output q, tc, wrap_flag
    );
endinterface

// File: rtl/updown_mod_counter.sv
// rtl/updown_mod_counter.sv - parametrised up/down modulo counter with prescaler, load/clear, tc pulse and sticky wrap flag
module updown_mod_counter #(
    parameter int unsigned     WIDTH    = 8,
    parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
    parameter int unsigned     PRESCALE = 1,
    parameter bit              SATURATE = 1'b0
) (
    input logic                 clk,
    input logic                 reset,
    updown_mod_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] q_r;
    logic             tc_r;
    logic             wf_r;
    logic             step;
    logic             at_bound;
    logic [WIDTH-1:0] load_q;

    // Widened compare keeps the clamp meaningful when MAX_VAL fills the whole word.
    assign load_q   = ({1'b0, bus.load_val} > {1'b0, MAX_Q}) ? MAX_Q : bus.load_val;
    assign at_bound = bus.up_dn ? (q_r == MAX_Q) : (q_r == '0);

    generate
        if (PRESCALE > 1) begin : g_pre
            localparam int unsigned PW = $clog2(PRESCALE);
            localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
            logic [PW-1:0] pre;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    pre <= '0;
                end else if (bus.clr || bus.load) begin
                    pre <= '0;
                end else if (bus.en) begin
                    pre <= (pre == PRE_LAST) ? '0 : pre + 1'b1;
                end
            end

            assign step = bus.en && (pre == PRE_LAST);
        end else begin : g_nopre
            assign step = bus.en;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_r  <= '0;
            tc_r <= 1'b0;
            wf_r <= 1'b0;
        end else if (bus.clr) begin
            q_r  <= '0;
            tc_r <= 1'b0;
            wf_r <= 1'b0;
        end else if (bus.load) begin
            q_r  <= load_q;
            tc_r <= 1'b0;
            if (bus.flag_clr) begin
                wf_r <= 1'b0;
            end
        end else begin
            tc_r <= 1'b0;
            if (bus.flag_clr) begin
                wf_r <= 1'b0;
            end
            // A boundary event sets the flag after flag_clr so that set wins.
            if (step) begin
                if (at_bound) begin
                    tc_r <= 1'b1;
                    wf_r <= 1'b1;
                    if (!SATURATE) begin
                        q_r <= bus.up_dn ? '0 : MAX_Q;
                    end
                end else begin
                    q_r <= bus.up_dn ? q_r + 1'b1 : q_r - 1'b1;
                end
            end
        end
    end

    assign bus.q         = q_r;
    assign bus.tc        = tc_r;
    assign bus.wrap_flag = wf_r;
endmodule

// File: tb/tb_updown_mod_counter.sv
// tb/tb_updown_mod_counter.sv - scoreboard bench for updown_mod_counter
module tb_updown_mod_counter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] q;
        logic       tc;
        logic       wf;
    } exp_t;

    typedef struct packed {
        logic       clr;
        logic       load;
        logic       en;
        logic       up;
        logic       fc;
        logic [7:0] lv;
        logic [7:0] eq;
        logic       etc;
        logic       ewf;
    } row_t;

    exp_t sb [$];
    int checks = 0;
    int errors = 0;

    updown_mod_counter_if #(.WIDTH(4)) w_if ();
    updown_mod_counter_if #(.WIDTH(4)) s_if ();
    updown_mod_counter_if #(.WIDTH(8)) p_if ();
    updown_mod_counter_if #(.WIDTH(4)) a_if ();
    updown_mod_counter_if #(.WIDTH(4)) b_if ();

    assign b_if.en = a_if.tc;

    updown_mod_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1), .SATURATE(1'b0))
        u_w (.clk(clk), .reset(reset), .bus(w_if));
    updown_mod_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1), .SATURATE(1'b1))
        u_s (.clk(clk), .reset(reset), .bus(s_if));
    updown_mod_counter #(.WIDTH(8), .MAX_VAL(255), .PRESCALE(3), .SATURATE(1'b0))
        u_p (.clk(clk), .reset(reset), .bus(p_if));
    updown_mod_counter #(.WIDTH(4), .MAX_VAL(3), .PRESCALE(1), .SATURATE(1'b0))
        u_a (.clk(clk), .reset(reset), .bus(a_if));
    updown_mod_counter #(.WIDTH(4), .MAX_VAL(15), .PRESCALE(1), .SATURATE(1'b0))
        u_b (.clk(clk), .reset(reset), .bus(b_if));

    task automatic init_inputs();
        w_if.en = 0; w_if.up_dn = 1; w_if.clr = 0; w_if.load = 0; w_if.load_val = '0; w_if.flag_clr = 0;
        s_if.en = 0; s_if.up_dn = 1; s_if.clr = 0; s_if.load = 0; s_if.load_val = '0; s_if.flag_clr = 0;
        p_if.en = 0; p_if.up_dn = 1; p_if.clr = 0; p_if.load = 0; p_if.load_val = '0; p_if.flag_clr = 0;
        a_if.en = 0; a_if.up_dn = 1; a_if.clr = 0; a_if.load = 0; a_if.load_val = '0; a_if.flag_clr = 0;
        b_if.up_dn = 1; b_if.clr = 0; b_if.load = 0; b_if.load_val = '0; b_if.flag_clr = 0;
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sb.push_back('{q: 8'd0, tc: 1'b0, wf: 1'b0});
        e = sb.pop_front();
        checks++;
        if ({4'b0, w_if.q} !== e.q || w_if.tc !== e.tc || w_if.wrap_flag !== e.wf) begin
            errors++;
            $display("FAIL reset_hold: q=%0d tc=%b wf=%b expected q=%0d tc=%b wf=%b", w_if.q, w_if.tc, w_if.wrap_flag, e.q, e.tc, e.wf);
        end
        reset = 1'b0;
        w_if.en = 1'b1;
        w_if.up_dn = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            sb.push_back('{q: 8'(i), tc: 1'b0, wf: 1'b0});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if ({4'b0, w_if.q} !== e.q || w_if.tc !== e.tc || w_if.wrap_flag !== e.wf) begin
                errors++;
                $display("FAIL reset_count step %0d: q=%0d tc=%b wf=%b expected q=%0d tc=%b wf=%b", i, w_if.q, w_if.tc, w_if.wrap_flag, e.q, e.tc, e.wf);
            end
        end
        #2;
        reset = 1'b1;
        sb.push_back('{q: 8'd0, tc: 1'b0, wf: 1'b0});
        #1;
        e = sb.pop_front();
        checks++;
        if ({4'b0, w_if.q} !== e.q || w_if.tc !== e.tc || w_if.wrap_flag !== e.wf) begin
            errors++;
            $display("FAIL reset_async: q=%0d tc=%b wf=%b expected q=%0d tc=%b wf=%b", w_if.q, w_if.tc, w_if.wrap_flag, e.q, e.tc, e.wf);
        end
        sb.push_back('{q: 8'd0, tc: 1'b0, wf: 1'b0});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        if ({4'b0, w_if.q} !== e.q || w_if.tc !== e.tc || w_if.wrap_flag !== e.wf) begin
            errors++;
            $display("FAIL reset_held_edge: q=%0d tc=%b wf=%b expected q=%0d tc=%b wf=%b", w_if.q, w_if.tc, w_if.wrap_flag, e.q, e.tc, e.wf);
        end
        reset = 1'b0;
        sb.push_back('{q: 8'd1, tc: 1'b0, wf: 1'b0});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        if ({4'b0, w_if.q} !== e.q || w_if.tc !== e.tc || w_if.wrap_flag !== e.wf) begin
            errors++;
            $display("FAIL reset_first_step: q=%0d tc=%b wf=%b expected q=%0d tc=%b wf=%b", w_if.q, w_if.tc, w_if.wrap_flag, e.q, e.tc, e.wf);
        end
        w_if.en = 1'b0;
    endtask

    task automatic test_up_wrap();
        exp_t e;
        w_if.clr = 1'b1;
        sb.push_back('{q: 8'd0, tc: 1'b0, wf: 1'b0});
        @(posedge clk);
        #1;
        w_if.clr = 1'b0;
        w_if.en = 1'b1;
        w_if.up_dn = 1'b1;
        for (int i = 0; i <= 12; i++) begin
            if (i > 0) begin
                sb.push_back('{q: 8'(i % 10), tc: (i == 10), wf: (i >= 10)});
                @(posedge clk);
                #1;
            end
            e = sb.pop_front();
            checks++;
            if ({4'b0, w_if.q} !== e.q || w_if.tc !== e.tc || w_if.wrap_flag !== e.wf) begin
                errors++;
                $display("FAIL up_wrap step %0d: q=%0d tc=%b wf=%b expected q=%0d tc=%b wf=%b", i, w_if.q, w_if.tc, w_if.wrap_flag, e.q, e.tc, e.wf);
            end
        end
        w_if.en = 1'b0;
    endtask

    task automatic test_load_clear();
        exp_t e;
        row_t tbl [8];
        tbl = '{
            '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd15, 8'd9, 1'b0, 1'b1},
            '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd4,  8'd0, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd4,  8'd4, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd7,  8'd7, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0,  8'd8, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0,  8'd9, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0,  8'd0, 1'b1, 1'b1},
            '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd3,  8'd3, 1'b0, 1'b0}
        };
        foreach (tbl[i]) begin
            w_if.clr = tbl[i].clr;
            w_if.load = tbl[i].load;
            w_if.en = tbl[i].en;
            w_if.up_dn = tbl[i].up;
            w_if.flag_clr = tbl[i].fc;
            w_if.load_val = tbl[i].lv[3:0];
            sb.push_back('{q: tbl[i].eq, tc: tbl[i].etc, wf: tbl[i].ewf});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if ({4'b0, w_if.q} !== e.q || w_if.tc !== e.tc || w_if.wrap_flag !== e.wf) begin
                errors++;
                $display("FAIL load_clear row %0d: q=%0d tc=%b wf=%b expected q=%0d tc=%b wf=%b", i, w_if.q, w_if.tc, w_if.wrap_flag, e.q, e.tc, e.wf);
            end
        end
        w_if.clr = 1'b0; w_if.load = 1'b0; w_if.en = 1'b0; w_if.flag_clr = 1'b0;
    endtask

    task automatic test_down_saturate();
        exp_t e;
        row_t tbl [10];
        tbl = '{
            '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 8'd2, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd1, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1},
            '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1},
            '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd9, 8'd9, 1'b0, 1'b1},
            '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd9, 1'b1, 1'b1},
            '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd9, 1'b1, 1'b1},
            '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd9, 1'b0, 1'b1},
            '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 8'd8, 1'b0, 1'b0}
        };
        foreach (tbl[i]) begin
            s_if.clr = tbl[i].clr;
            s_if.load = tbl[i].load;
            s_if.en = tbl[i].en;
            s_if.up_dn = tbl[i].up;
            s_if.flag_clr = tbl[i].fc;
            s_if.load_val = tbl[i].lv[3:0];
            sb.push_back('{q: tbl[i].eq, tc: tbl[i].etc, wf: tbl[i].ewf});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if ({4'b0, s_if.q} !== e.q || s_if.tc !== e.tc || s_if.wrap_flag !== e.wf) begin
                errors++;
                $display("FAIL down_saturate row %0d: q=%0d tc=%b wf=%b expected q=%0d tc=%b wf=%b", i, s_if.q, s_if.tc, s_if.wrap_flag, e.q, e.tc, e.wf);
            end
        end
        s_if.load = 1'b0; s_if.en = 1'b0; s_if.flag_clr = 1'b0;
    endtask

    task automatic test_prescaler();
        exp_t e;
        int pen [14] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
        int pup [14] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
        int pq  [14] = '{0, 0, 1, 1, 1, 1, 1, 2, 2, 2, 3, 3, 3, 2};
        for (int i = 0; i < 14; i++) begin
            p_if.en = pen[i][0];
            p_if.up_dn = pup[i][0];
            sb.push_back('{q: 8'(pq[i]), tc: 1'b0, wf: 1'b0});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if (p_if.q !== e.q || p_if.tc !== e.tc || p_if.wrap_flag !== e.wf) begin
                errors++;
                $display("FAIL prescaler edge %0d: q=%0d tc=%b wf=%b expected q=%0d tc=%b wf=%b", i + 1, p_if.q, p_if.tc, p_if.wrap_flag, e.q, e.tc, e.wf);
            end
        end
        p_if.en = 1'b0;
    endtask

    task automatic test_cascade();
        exp_t e;
        int  a_q = 0;
        int  b_q = 0;
        bit  a_tc = 1'b0;
        bit  a_wf = 1'b0;
        bit  b_tc = 1'b0;
        bit  b_wf = 1'b0;
        bit  fc;
        bit  a_bnd;
        bit  b_bnd;
        a_if.en = 1'b1;
        a_if.up_dn = 1'b1;
        b_if.up_dn = 1'b1;
        for (int i = 1; i <= 21; i++) begin
            fc = (i == 18) || (i == 20) || (i == 21);
            a_if.flag_clr = fc;
            a_bnd = (a_q == 3);
            b_bnd = a_tc && (b_q == 15);
            b_wf = b_bnd | b_wf;
            b_tc = b_bnd;
            if (a_tc) b_q = (b_q + 1) % 16;
            a_wf = a_bnd | (a_wf & ~fc);
            a_tc = a_bnd;
            a_q = (a_q + 1) % 4;
            sb.push_back('{q: 8'(a_q), tc: a_tc, wf: a_wf});
            sb.push_back('{q: 8'(b_q), tc: b_tc, wf: b_wf});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if ({4'b0, a_if.q} !== e.q || a_if.tc !== e.tc || a_if.wrap_flag !== e.wf) begin
                errors++;
                $display("FAIL cascade_a edge %0d: q=%0d tc=%b wf=%b expected q=%0d tc=%b wf=%b", i, a_if.q, a_if.tc, a_if.wrap_flag, e.q, e.tc, e.wf);
            end
            e = sb.pop_front();
            checks++;
            if ({4'b0, b_if.q} !== e.q || b_if.tc !== e.tc || b_if.wrap_flag !== e.wf) begin
                errors++;
                $display("FAIL cascade_b edge %0d: q=%0d tc=%b wf=%b expected q=%0d tc=%b wf=%b", i, b_if.q, b_if.tc, b_if.wrap_flag, e.q, e.tc, e.wf);
            end
        end
        a_if.en = 1'b0;
        a_if.flag_clr = 1'b0;
    endtask

    initial begin
        init_inputs();
        test_reset();
        test_up_wrap();
        test_load_clear();
        test_down_saturate();
        test_prescaler();
        test_cascade();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: left=%0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
